// File: rtl/alu_pkg.sv
// ----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the y86-64 execute stage:
//   - ALU function codes (ifun field of OPq)
//   - bit positions of the condition codes inside a packed {ZF,SF,OF} vector
//   - cc_t, the condition-code register type
//   - alu_is_legal(), which tells whether an ifun selects a real ALU operation
// ----------------------------------------------------------------------------
package alu_pkg;

    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SUB = 4'd1;
    localparam logic [3:0] ALU_AND = 4'd2;
    localparam logic [3:0] ALU_XOR = 4'd3;

    localparam int CC_ZF = 2;
    localparam int CC_SF = 1;
    localparam int CC_OF = 0;

    // Field order matches the CC_* indices: zf is bit 2, of is bit 0.
    typedef struct packed {
        logic zf;
        logic sf;
        logic of;
    } cc_t;

    function automatic logic alu_is_legal(input logic [3:0] ifun);
        return (ifun == ALU_ADD) || (ifun == ALU_SUB) ||
               (ifun == ALU_AND) || (ifun == ALU_XOR);
    endfunction

endpackage : alu_pkg

// File: rtl/alu_core.sv
// ----------------------------------------------------------------------------
// alu_core
// Purely combinational y86-64 ALU. Operand order follows y86: the result is
// valB <op> valA. Flags are derived from the produced result; an illegal
// ifun forces valE to zero and raises illegal. The flag outputs are still
// driven for an illegal ifun but carry no meaning, so the caller must not
// load them into the CC register in that case.
//
// Ports:
//   ifun     in   4  ALU function code (ALU_ADD/SUB/AND/XOR, others illegal)
//   valA     in   W  operand A (rA value)
//   valB     in   W  operand B (rB value)
//   valE     out  W  result, wrapped modulo 2^W
//   zf       out  1  result is zero
//   sf       out  1  result sign bit
//   of       out  1  signed overflow (ADD/SUB only, 0 for logic ops)
//   illegal  out  1  ifun is not a defined ALU operation
// ----------------------------------------------------------------------------
module alu_core
    import alu_pkg::*;
#(
    parameter int W = 64
) (
    input  logic [3:0]   ifun,
    input  logic [W-1:0] valA,
    input  logic [W-1:0] valB,
    output logic [W-1:0] valE,
    output logic         zf,
    output logic         sf,
    output logic         of,
    output logic         illegal
);

    logic [W-1:0] sum;
    logic [W-1:0] diff;
    logic         sign_a;
    logic         sign_b;

    assign sum    = valB + valA;
    assign diff   = valB - valA;
    assign sign_a = valA[W-1];
    assign sign_b = valB[W-1];

    // Overflow on ADD: operands share a sign and the result sign differs.
    // Overflow on SUB: operands differ in sign and the result sign leaves
    // that of the minuend (valB).
    always_comb begin
        valE    = '0;
        of      = 1'b0;
        illegal = 1'b0;
        case (ifun)
            ALU_ADD: begin
                valE = sum;
                of   = (sign_a == sign_b) && (sum[W-1] != sign_b);
            end
            ALU_SUB: begin
                valE = diff;
                of   = (sign_a != sign_b) && (diff[W-1] != sign_b);
            end
            ALU_AND: begin
                valE = valB & valA;
            end
            ALU_XOR: begin
                valE = valB ^ valA;
            end
            default: begin
                illegal = 1'b1;
            end
        endcase
    end

    assign zf = (valE == '0);
    assign sf = valE[W-1];

endmodule : alu_core

// File: rtl/alu_cc_stage.sv
// ----------------------------------------------------------------------------
// alu_cc_stage
// Execute stage of the y86-64 pipeline. Takes an operand bundle over a
// valid/ready handshake, runs it through alu_core and registers valE/err
// for the memory stage with one cycle of latency. It also owns the
// architectural condition-code register {ZF,SF,OF}.
//
// The output register is a single-entry skid-free slot: a new bundle may be
// accepted on the same edge the current one is consumed, so a stream runs
// at one bundle per cycle without bubbles.
//
// Ports:
//   clk        in   1  clock, rising edge
//   rst        in   1  synchronous active-high reset
//   in_valid   in   1  operand bundle valid
//   in_ready   out  1  stage can take a bundle this cycle
//   in_ifun    in   4  ALU function code
//   in_valA    in   W  operand A
//   in_valB    in   W  operand B
//   in_set_cc  in   1  bundle updates CC (OPq)
//   cc_hold    in   1  downstream exception/bubble, blocks CC update
//   out_valid  out  1  out_valE/out_err hold a live result
//   out_ready  in   1  consumer takes the result
//   out_valE   out  W  registered result
//   out_err    out  1  registered illegal-ifun flag
//   cc_zf      out  1  zero flag
//   cc_sf      out  1  sign flag
//   cc_of      out  1  signed-overflow flag
// ----------------------------------------------------------------------------
module alu_cc_stage
    import alu_pkg::*;
#(
    parameter int         W        = 64,
    parameter logic [2:0] CC_RESET = 3'b100
) (
    input  logic         clk,
    input  logic         rst,

    input  logic         in_valid,
    output logic         in_ready,
    input  logic [3:0]   in_ifun,
    input  logic [W-1:0] in_valA,
    input  logic [W-1:0] in_valB,
    input  logic         in_set_cc,
    input  logic         cc_hold,

    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_valE,
    output logic         out_err,

    output logic         cc_zf,
    output logic         cc_sf,
    output logic         cc_of
);

    logic [W-1:0] core_valE;
    logic         core_zf;
    logic         core_sf;
    logic         core_of;
    logic         core_illegal;

    logic         accept;
    logic         cc_we;
    cc_t          cc_q;
    cc_t          cc_new;

    alu_core #(
        .W (W)
    ) u_alu_core (
        .ifun    (in_ifun),
        .valA    (in_valA),
        .valB    (in_valB),
        .valE    (core_valE),
        .zf      (core_zf),
        .sf      (core_sf),
        .of      (core_of),
        .illegal (core_illegal)
    );

    // The slot frees up on the same edge it is consumed, so readiness looks
    // straight through to out_ready.
    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;

    // An illegal ifun still travels down the pipe (flagged by out_err) but
    // must never disturb the architectural flags.
    assign cc_we  = accept && in_set_cc && !cc_hold && !core_illegal;
    assign cc_new = '{zf: core_zf, sf: core_sf, of: core_of};

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_valE  <= '0;
            out_err   <= 1'b0;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_valE  <= core_valE;
            out_err   <= core_illegal;
        end else if (out_ready) begin
            // Result consumed with nothing behind it; data is left in place.
            out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cc_q <= cc_t'(CC_RESET);
        end else if (cc_we) begin
            cc_q <= cc_new;
        end
    end

    assign cc_zf = cc_q.zf;
    assign cc_sf = cc_q.sf;
    assign cc_of = cc_q.of;

endmodule : alu_cc_stage

// File: tb/tb_alu_cc_stage.sv
// ----------------------------------------------------------------------------
// tb_alu_cc_stage
// Self-checking bench for alu_cc_stage. A transaction-level model advances
// once per rising edge; a compare process checks every DUT output against it
// on each falling edge. Directed sequences pin the model with literal
// expectations, then a randomized phase exercises handshake, CC gating,
// illegal codes and reset.
// ----------------------------------------------------------------------------
module tb_alu_cc_stage;

    localparam int W = 64;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [3:0]   in_ifun;
    logic [W-1:0] in_valA;
    logic [W-1:0] in_valB;
    logic         in_set_cc;
    logic         cc_hold;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_valE;
    logic         out_err;
    logic         cc_zf;
    logic         cc_sf;
    logic         cc_of;

    int total = 0;
    int bad   = 0;
    bit started = 1'b0;

    always #5 clk = ~clk;

    alu_cc_stage #(
        .W        (W),
        .CC_RESET (3'b100)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_ifun   (in_ifun),
        .in_valA   (in_valA),
        .in_valB   (in_valB),
        .in_set_cc (in_set_cc),
        .cc_hold   (cc_hold),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_valE  (out_valE),
        .out_err   (out_err),
        .cc_zf     (cc_zf),
        .cc_sf     (cc_sf),
        .cc_of     (cc_of)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic        valid;
        logic [63:0] valE;
        logic        err;
        logic [2:0]  cc;
    } mstate_t;

    mstate_t m = '{valid: 1'b0, valE: 64'd0, err: 1'b0, cc: 3'b100};

    // Overflow is found by doing the arithmetic one bit wider and asking
    // whether the wrapped 64-bit result still equals the true signed value.
    function automatic void ref_alu(input logic [3:0] f, input logic [63:0] a,
                                    input logic [63:0] b, output logic [63:0] e,
                                    output logic err, output logic [2:0] cc);
        logic signed [64:0] wide;
        logic ofl;
        e = 64'd0; err = 1'b0; ofl = 1'b0;
        case (f)
            4'd0: begin
                e = b + a;
                wide = $signed({b[63], b}) + $signed({a[63], a});
                ofl = (wide != $signed({e[63], e}));
            end
            4'd1: begin
                e = b - a;
                wide = $signed({b[63], b}) - $signed({a[63], a});
                ofl = (wide != $signed({e[63], e}));
            end
            4'd2: e = b & a;
            4'd3: e = b ^ a;
            default: err = 1'b1;
        endcase
        cc = {(e == 64'd0), e[63], ofl};
    endfunction

    function automatic mstate_t model_step(input mstate_t s, input logic r, input logic v,
                                           input logic ordy, input logic [3:0] f,
                                           input logic [63:0] a, input logic [63:0] b,
                                           input logic sc, input logic hold);
        mstate_t n;
        logic [63:0] e;
        logic er;
        logic [2:0] c;
        n = s;
        if (r) begin
            n = '{valid: 1'b0, valE: 64'd0, err: 1'b0, cc: 3'b100};
        end else if (v && (!s.valid || ordy)) begin
            ref_alu(f, a, b, e, er, c);
            n.valid = 1'b1;
            n.valE  = e;
            n.err   = er;
            if (sc && !hold && !er) n.cc = c;
        end else if (ordy) begin
            n.valid = 1'b0;
        end
        return n;
    endfunction

    always @(posedge clk)
        m <= model_step(m, rst, in_valid, out_ready, in_ifun, in_valA, in_valB,
                        in_set_cc, cc_hold);

    always @(negedge clk) begin
        if (started) begin
            chk("out_valid", out_valid, m.valid);
            chk("in_ready", in_ready, !m.valid || out_ready);
            chk("out_valE", out_valE, m.valE);
            chk("out_err", out_err, m.err);
            chk("cc", {cc_zf, cc_sf, cc_of}, m.cc);
        end
    end

    // ---------------- directed helpers ----------------
    task automatic send(input logic [3:0] f, input logic [63:0] a, input logic [63:0] b,
                        input logic sc, input logic hold);
        bit done = 1'b0;
        int n = 0;
        @(posedge clk); #1;
        in_valid = 1'b1; in_ifun = f; in_valA = a; in_valB = b;
        in_set_cc = sc; cc_hold = hold;
        while (!done && n < 50) begin
            @(negedge clk);
            if (in_ready) done = 1'b1;
            @(posedge clk); #1;
            n++;
        end
        in_valid = 1'b0;
        chk("send_accept", done, 1'b1);
    endtask

    task automatic lit(input string nm, input logic [63:0] e_val, input logic e_err,
                       input logic [2:0] e_cc);
        @(negedge clk);
        chk({nm, "_valid"}, out_valid, 1'b1);
        chk({nm, "_valE"}, out_valE, e_val);
        chk({nm, "_err"}, out_err, e_err);
        chk({nm, "_cc"}, {cc_zf, cc_sf, cc_of}, e_cc);
    endtask

    function automatic logic [63:0] rnd64();
        case ($urandom_range(0, 7))
            0: return 64'd0;
            1: return 64'hFFFF_FFFF_FFFF_FFFF;
            2: return 64'h7FFF_FFFF_FFFF_FFFF;
            3: return 64'h8000_0000_0000_0000;
            4: return 64'($urandom_range(0, 15));
            default: return {$urandom, $urandom};
        endcase
    endfunction

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_ifun = 4'd0; in_valA = '0; in_valB = '0;
        in_set_cc = 1'b0; cc_hold = 1'b0; out_ready = 1'b1;

        // 1. reset held two cycles
        @(posedge clk); #1;
        started = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_valid", out_valid, 1'b0);
        chk("rst_valE", out_valE, 64'd0);
        chk("rst_err", out_err, 1'b0);
        chk("rst_cc", {cc_zf, cc_sf, cc_of}, 3'b100);
        chk("rst_in_ready", in_ready, 1'b1);

        // 2. SUB both directions
        send(4'd1, 64'd3, 64'd10, 1'b1, 1'b0);
        lit("sub_pos", 64'd7, 1'b0, 3'b000);
        send(4'd1, 64'd10, 64'd3, 1'b1, 1'b0);
        lit("sub_neg", 64'hFFFF_FFFF_FFFF_FFF9, 1'b0, 3'b010);

        // 3. signed overflow edges
        send(4'd0, 64'd1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b0);
        lit("add_ovf", 64'h8000_0000_0000_0000, 1'b0, 3'b011);
        send(4'd1, 64'd1, 64'h8000_0000_0000_0000, 1'b1, 1'b0);
        lit("sub_ovf", 64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 3'b001);

        // 4. XOR to zero, then CC gating by set_cc and cc_hold
        send(4'd3, 64'h5A5A_5A5A_5A5A_5A5A, 64'h5A5A_5A5A_5A5A_5A5A, 1'b1, 1'b0);
        lit("xor_zero", 64'd0, 1'b0, 3'b100);
        send(4'd0, 64'd1, 64'd1, 1'b1, 1'b0);
        lit("add_two", 64'd2, 1'b0, 3'b000);
        send(4'd3, 64'h5A5A_5A5A_5A5A_5A5A, 64'h5A5A_5A5A_5A5A_5A5A, 1'b0, 1'b0);
        lit("xor_noset", 64'd0, 1'b0, 3'b000);
        send(4'd3, 64'h5A5A_5A5A_5A5A_5A5A, 64'h5A5A_5A5A_5A5A_5A5A, 1'b1, 1'b1);
        lit("xor_hold", 64'd0, 1'b0, 3'b000);

        // 5. backpressure with a second bundle waiting
        send(4'd0, 64'd5, 64'd5, 1'b1, 1'b0);
        out_ready = 1'b0;
        in_valid = 1'b1; in_ifun = 4'd1; in_valA = 64'd5; in_valB = 64'd5;
        in_set_cc = 1'b1; cc_hold = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_in_ready", in_ready, 1'b0);
            chk("bp_valE", out_valE, 64'd10);
            chk("bp_cc", {cc_zf, cc_sf, cc_of}, 3'b000);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_ready", in_ready, 1'b1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        lit("bp_second", 64'd0, 1'b0, 3'b100);

        // 6. illegal op, then reset during a stall
        send(4'd0, 64'd1, 64'd1, 1'b1, 1'b0);
        lit("pre_ill", 64'd2, 1'b0, 3'b000);
        send(4'd5, 64'd1, 64'd2, 1'b1, 1'b0);
        lit("illegal", 64'd0, 1'b1, 3'b000);
        out_ready = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_stall_valid", out_valid, 1'b0);
        chk("rst_stall_cc", {cc_zf, cc_sf, cc_of}, 3'b100);
        chk("rst_stall_err", out_err, 1'b0);
        chk("rst_stall_valE", out_valE, 64'd0);

        // randomized phase; compare process does the checking
        for (int c = 0; c < 4000; c++) begin
            @(posedge clk); #1;
            rst       = ($urandom_range(0, 199) == 0);
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            in_ifun   = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(4, 15))
                                                    : 4'($urandom_range(0, 3));
            in_valA   = rnd64();
            in_valB   = ($urandom_range(0, 5) == 0) ? in_valA : rnd64();
            in_set_cc = ($urandom_range(0, 3) != 0);
            cc_hold   = ($urandom_range(0, 4) == 0);
        end
        @(posedge clk); #1;
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_alu_cc_stage
